scr1_tb_ahb_stall_inj: RTL and testbench

- AHB-Lite wait-state injector placed between a core AHB master port (imem or dmem) and the testbench AHB memory model.
- Re-issues each master transfer to the memory, inserting pattern-controlled extra wait states ahead of it.
- Stresses core fetch/LSU back-pressure handling under regression.
- Non-pipelined toward memory: at most one outstanding transfer.

---
 rtl/scr1_tb_ahb_stall_inj_pkg.sv | 22 ++
 rtl/scr1_tb_stall_pattern_gen.sv | 56 +++++
 rtl/scr1_tb_ahb_stall_inj.sv | 194 +++++++++++++++++++
 tb/tb_scr1_tb_ahb_stall_inj.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_tb_ahb_stall_inj_pkg.sv
// Shared AHB-Lite encodings and helpers for the testbench wait-state injector.
// Mirrors the subset of the SCR1 AHB header that the injector relies on.
package scr1_tb_ahb_stall_inj_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic SCR1_HRESP_OKAY = 1'b0;

  // NONSEQ or SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == SCR1_HTRANS_NONSEQ) || (htrans == SCR1_HTRANS_SEQ);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
  endfunction

endpackage

// File: rtl/scr1_tb_stall_pattern_gen.sv
// Stall pattern register and stall-length counter for the AHB wait-state injector.
// The MSB of the pattern decides whether the transfer being captured is stalled.
module scr1_tb_stall_pattern_gen
  import scr1_tb_ahb_stall_inj_pkg::*;
#(
  parameter int STALL_W      = 4,
  parameter int STALL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_load,
  input  logic [31:0] cfg_pattern,
  input  logic        capture,
  input  logic        in_stall,
  output logic        stall_req,
  output logic        stall_done
);

  localparam logic [STALL_W-1:0] STALL_LEN = STALL_W'(STALL_CYCLES);
  localparam logic [STALL_W-1:0] CNT_ONE   = STALL_W'(1);
  localparam logic [STALL_W-1:0] CNT_ZERO  = STALL_W'(0);
  localparam logic               STALL_EN  = (STALL_CYCLES != 0);

  logic [31:0]        pattern_r;
  logic [STALL_W-1:0] cnt_r;

  assign stall_req  = pattern_r[31] & STALL_EN;
  assign stall_done = (cnt_r == CNT_ONE);

  // Pattern register: a load wins over rotation, so a coinciding load lands un-rotated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= 32'h0000_0000;
    end else if (cfg_load) begin
      pattern_r <= cfg_pattern;
    end else if (capture) begin
      pattern_r <= {pattern_r[30:0], pattern_r[31]};
    end else begin
      pattern_r <= pattern_r;
    end
  end

  // Stall-length counter: loaded on a stalled capture, counts down while stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (capture && stall_req) begin
      cnt_r <= STALL_LEN;
    end else if (in_stall && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/scr1_tb_ahb_stall_inj.sv
// AHB-Lite wait-state injector between a core master port and the testbench memory.
// Re-issues each accepted transfer to memory, optionally preceded by stall cycles.
module scr1_tb_ahb_stall_inj
  import scr1_tb_ahb_stall_inj_pkg::*;
#(
  parameter int AHB_W        = SCR1_AHB_WIDTH,
  parameter int STALL_W      = 4,
  parameter int STALL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [31:0]      cfg_pattern,
  input  logic [1:0]       s_htrans,
  input  logic [AHB_W-1:0] s_haddr,
  input  logic             s_hwrite,
  input  logic [2:0]       s_hsize,
  input  logic [2:0]       s_hburst,
  input  logic [3:0]       s_hprot,
  input  logic [AHB_W-1:0] s_hwdata,
  output logic             s_hready,
  output logic [AHB_W-1:0] s_hrdata,
  output logic             s_hresp,
  output logic [1:0]       m_htrans,
  output logic [AHB_W-1:0] m_haddr,
  output logic             m_hwrite,
  output logic [2:0]       m_hsize,
  output logic [2:0]       m_hburst,
  output logic [3:0]       m_hprot,
  output logic [AHB_W-1:0] m_hwdata,
  input  logic             m_hready,
  input  logic [AHB_W-1:0] m_hrdata,
  input  logic             m_hresp,
  output logic [31:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_ADDR  = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             s_hready_s;
  logic             accept_s;
  logic             stall_req_s;
  logic             stall_done_s;
  logic             in_stall_s;
  logic [AHB_W-1:0] haddr_r;
  logic             hwrite_r;
  logic [2:0]       hsize_r;
  logic [2:0]       hburst_r;
  logic [3:0]       hprot_r;
  logic [31:0]      xfer_cnt_r;

  assign in_stall_s = (state_r == ST_STALL);
  assign accept_s   = s_hready_s & htrans_active(s_htrans);

  scr1_tb_stall_pattern_gen #(
    .STALL_W      (STALL_W),
    .STALL_CYCLES (STALL_CYCLES)
  ) i_pattern_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .capture     (accept_s),
    .in_stall    (in_stall_s),
    .stall_req   (stall_req_s),
    .stall_done  (stall_done_s)
  );

  // Ready toward the master: free in IDLE, mirrors memory in DATA, held low otherwise.
  always_comb begin
    s_hready_s = 1'b0;
    case (state_r)
      ST_IDLE: s_hready_s = 1'b1;
      ST_DATA: s_hready_s = m_hready;
      default: s_hready_s = 1'b0;
    endcase
  end

  // Next-state logic; a capture in the last data cycle chains straight into the next transfer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = stall_req_s ? ST_STALL : ST_ADDR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (stall_done_s) begin
          state_next_s = ST_ADDR;
        end else begin
          state_next_s = ST_STALL;
        end
      end
      ST_ADDR: begin
        if (m_hready) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (m_hready && accept_s) begin
          state_next_s = stall_req_s ? ST_STALL : ST_ADDR;
        end else if (m_hready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Address-phase capture of the accepted master transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haddr_r  <= {AHB_W{1'b0}};
      hwrite_r <= 1'b0;
      hsize_r  <= 3'b000;
      hburst_r <= 3'b000;
      hprot_r  <= 4'b0000;
    end else if (accept_s) begin
      haddr_r  <= s_haddr;
      hwrite_r <= s_hwrite;
      hsize_r  <= s_hsize;
      hburst_r <= s_hburst;
      hprot_r  <= s_hprot;
    end else begin
      haddr_r  <= haddr_r;
      hwrite_r <= hwrite_r;
      hsize_r  <= hsize_r;
      hburst_r <= hburst_r;
      hprot_r  <= hprot_r;
    end
  end

  // Completed-transfer counter; an ERROR completion counts as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_r <= 32'h0000_0000;
    end else if ((state_r == ST_DATA) && m_hready) begin
      xfer_cnt_r <= sat_inc32(xfer_cnt_r);
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  // Bus outputs; captured fields stay on m_* so they are stable across ADDR wait states.
  always_comb begin
    s_hready = s_hready_s;
    s_hrdata = {AHB_W{1'b0}};
    s_hresp  = SCR1_HRESP_OKAY;
    m_htrans = SCR1_HTRANS_IDLE;
    m_haddr  = haddr_r;
    m_hwrite = hwrite_r;
    m_hsize  = hsize_r;
    m_hburst = hburst_r;
    m_hprot  = hprot_r;
    m_hwdata = {AHB_W{1'b0}};
    xfer_cnt = xfer_cnt_r;
    case (state_r)
      ST_ADDR: begin
        m_htrans = SCR1_HTRANS_NONSEQ;
      end
      ST_DATA: begin
        s_hrdata = m_hrdata;
        s_hresp  = m_hresp;
        m_hwdata = s_hwdata;
      end
      default: begin
        m_htrans = SCR1_HTRANS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scr1_tb_ahb_stall_inj.sv
// Self-checking bench: AHB master + memory models around the injector, with a
// transaction-level scoreboard for stall placement, latency, data and counters.
module tb_scr1_tb_ahb_stall_inj;

  localparam int AHB_W = 32;
  localparam int SC    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_load;
  logic [31:0]      cfg_pattern;
  logic [1:0]       s_htrans;
  logic [AHB_W-1:0] s_haddr;
  logic             s_hwrite;
  logic [2:0]       s_hsize;
  logic [2:0]       s_hburst;
  logic [3:0]       s_hprot;
  logic [AHB_W-1:0] s_hwdata;
  logic             s_hready;
  logic [AHB_W-1:0] s_hrdata;
  logic             s_hresp;
  logic [1:0]       m_htrans;
  logic [AHB_W-1:0] m_haddr;
  logic             m_hwrite;
  logic [2:0]       m_hsize;
  logic [2:0]       m_hburst;
  logic [3:0]       m_hprot;
  logic [AHB_W-1:0] m_hwdata;
  logic             m_hready;
  logic [AHB_W-1:0] m_hrdata;
  logic             m_hresp;
  logic [31:0]      xfer_cnt;

  always #5 clk = ~clk;

  scr1_tb_ahb_stall_inj #(
    .AHB_W        (AHB_W),
    .STALL_W      (4),
    .STALL_CYCLES (SC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .s_htrans    (s_htrans),
    .s_haddr     (s_haddr),
    .s_hwrite    (s_hwrite),
    .s_hsize     (s_hsize),
    .s_hburst    (s_hburst),
    .s_hprot     (s_hprot),
    .s_hwdata    (s_hwdata),
    .s_hready    (s_hready),
    .s_hrdata    (s_hrdata),
    .s_hresp     (s_hresp),
    .m_htrans    (m_htrans),
    .m_haddr     (m_haddr),
    .m_hwrite    (m_hwrite),
    .m_hsize     (m_hsize),
    .m_hburst    (m_hburst),
    .m_hprot     (m_hprot),
    .m_hwdata    (m_hwdata),
    .m_hready    (m_hready),
    .m_hrdata    (m_hrdata),
    .m_hresp     (m_hresp),
    .xfer_cnt    (xfer_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        seq;
    int          gap;
  } tx_t;

  typedef struct {
    int  cyc;
    int  stall;
    tx_t tx;
  } acc_t;

  typedef struct {
    int waits;
    int err;
  } mlog_t;

  tx_t   txq[$];
  acc_t  accq[$];
  mlog_t mlog[$];
  tx_t   ap;
  tx_t   dp;
  bit    ap_valid;
  bit    dp_valid;
  bit    busy_noise;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem     [logic [31:0]];

  int n_checks;
  int n_fail;
  int cyc;
  int completions;
  int base;

  bit          mdp_valid;
  bit          mdp_wr;
  bit          merr;
  bit          merr_first;
  logic [31:0] mdp_addr;
  int          mwait_left;
  int          wait_min;
  int          wait_max;
  int          err_pct;
  int          force_err;
  logic        n_hready;
  logic        n_hresp;
  logic [31:0] n_hrdata;

  logic [31:0] load_word;
  int          caps_since_load;
  bit          cfg_req;
  logic [31:0] cfg_val;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", tag, cyc);
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // k-th capture since the last pattern load looks at bit 31-k (mod 32) of the loaded word.
  function automatic int exp_stall();
    int idx;
    idx = 31 - (caps_since_load % 32);
    return (load_word[idx] && (SC > 0)) ? SC : 0;
  endfunction

  function automatic tx_t mk_tx(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input int gap);
    tx_t t;
    t.addr  = addr;
    t.wr    = wr;
    t.wdata = wdata;
    t.size  = 3'b010;
    t.burst = 3'b000;
    t.prot  = 4'b0011;
    t.seq   = 1'b0;
    t.gap   = gap;
    return t;
  endfunction

  function automatic tx_t rand_tx();
    tx_t t;
    t.addr  = 32'h0000_1000 + 32'($urandom_range(7, 0)) * 32'd4;
    t.wr    = 1'($urandom_range(1, 0));
    t.wdata = $urandom;
    t.size  = 3'($urandom_range(2, 0));
    t.burst = 3'($urandom_range(7, 0));
    t.prot  = 4'($urandom_range(15, 0));
    t.seq   = 1'($urandom_range(1, 0));
    t.gap   = $urandom_range(2, 0);
    return t;
  endfunction

  task automatic drive();
    if (ap_valid) begin
      s_htrans = ap.seq ? 2'b11 : 2'b10;
      s_haddr  = ap.addr;
      s_hwrite = ap.wr;
      s_hsize  = ap.size;
      s_hburst = ap.burst;
      s_hprot  = ap.prot;
    end else begin
      s_htrans = (busy_noise && ($urandom_range(3, 0) == 0)) ? 2'b01 : 2'b00;
      s_haddr  = 32'hBAD0_0000;
      s_hwrite = 1'b1;
      s_hsize  = 3'b000;
      s_hburst = 3'b000;
      s_hprot  = 4'b0000;
    end
    s_hwdata    = dp_valid ? dp.wdata : 32'h0000_0000;
    m_hready    = n_hready;
    m_hresp     = n_hresp;
    m_hrdata    = n_hrdata;
    cfg_load    = cfg_req;
    cfg_pattern = cfg_val;
    cfg_req     = 1'b0;
  endtask

  task automatic complete_dp();
    acc_t  a;
    mlog_t ml;
    if (accq.size() == 0 || mlog.size() == 0) begin
      fail_now("scoreboard_empty");
    end else begin
      a  = accq.pop_front();
      ml = mlog.pop_front();
      check_eq("latency", 32'(cyc - a.cyc), 32'(a.stall + 2 + ml.waits + ml.err));
      check_eq("s_hresp", {31'd0, s_hresp}, 32'(ml.err));
      if (ml.err == 0 && !dp.wr) check_eq("rdata", s_hrdata, ref_rd(dp.addr));
      if (ml.err == 0 && dp.wr) ref_mem[dp.addr] = dp.wdata;
    end
    check_eq("xfer_cnt", xfer_cnt, 32'(completions));
    completions++;
  endtask

  task automatic mem_addr_phase();
    acc_t  a;
    mlog_t ml;
    if (accq.size() == 0) begin
      fail_now("spurious_nonseq");
    end else begin
      a = accq[accq.size()-1];
      check_eq("stall_gap", 32'(cyc - a.cyc - 1), 32'(a.stall));
      check_eq("m_haddr", m_haddr, a.tx.addr);
      check_eq("m_ctrl", {21'd0, m_hwrite, m_hsize, m_hburst, m_hprot},
               {21'd0, a.tx.wr, a.tx.size, a.tx.burst, a.tx.prot});
    end
    ml.waits = $urandom_range(wait_max, wait_min);
    ml.err   = ((force_err > 0) || ($urandom_range(99, 0) < err_pct)) ? 1 : 0;
    if (force_err > 0) force_err--;
    mdp_valid  = 1'b1;
    mdp_addr   = m_haddr;
    mdp_wr     = m_hwrite;
    mwait_left = ml.waits;
    merr       = (ml.err != 0);
    merr_first = 1'b0;
    mlog.push_back(ml);
  endtask

  // One clock: observe at negedge, update models, drive next-cycle inputs after posedge.
  task automatic step();
    acc_t a;
    @(negedge clk);
    cyc++;
    if (mdp_valid) check_eq("hready_mirror", {31'd0, s_hready}, {31'd0, m_hready});
    if (mdp_valid && mdp_wr) check_eq("m_hwdata", m_hwdata, dp.wdata);
    if (mdp_valid && m_hready) begin
      if (mdp_wr && !merr) mem[mdp_addr] = m_hwdata;
      mdp_valid = 1'b0;
    end
    if (m_hready && m_htrans == 2'b10) mem_addr_phase();
    else if (m_htrans != 2'b00) check_eq("m_htrans", {30'd0, m_htrans}, 32'd0);
    if (mdp_valid) begin
      if (mwait_left > 0) begin
        n_hready = 1'b0; n_hresp = 1'b0; n_hrdata = 32'h0; mwait_left--;
      end else if (merr && !merr_first) begin
        n_hready = 1'b0; n_hresp = 1'b1; n_hrdata = 32'h0; merr_first = 1'b1;
      end else begin
        n_hready = 1'b1; n_hresp = merr;
        n_hrdata = (merr || mdp_wr) ? 32'h0 : mem_rd(mdp_addr);
      end
    end else begin
      n_hready = 1'b1; n_hresp = 1'b0; n_hrdata = 32'h0;
    end
    if (s_hready && !dp_valid) check_eq("hrdata_idle", s_hrdata, 32'h0);
    if (s_hready) begin
      if (dp_valid) complete_dp();
      dp_valid = 1'b0;
      if (ap_valid) begin
        a.cyc   = cyc;
        a.stall = exp_stall();
        a.tx    = ap;
        accq.push_back(a);
        caps_since_load++;
        dp       = ap;
        dp_valid = 1'b1;
        ap_valid = 1'b0;
      end
    end
    if (cfg_load) begin
      load_word       = cfg_pattern;
      caps_since_load = 0;
    end
    if (!ap_valid && txq.size() > 0) begin
      if (txq[0].gap > 0) txq[0].gap = txq[0].gap - 1;
      else begin
        ap       = txq.pop_front();
        ap_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((txq.size() > 0 || ap_valid || dp_valid) && n < budget) begin
      step();
      n++;
    end
    if (txq.size() > 0 || ap_valid || dp_valid) begin
      fail_now("timeout_waiting_for_idle");
      finish_test();
    end
    check_eq("xfer_cnt_end", xfer_cnt, 32'(completions));
  endtask

  task automatic load_cfg(input logic [31:0] val);
    cfg_req = 1'b1;
    cfg_val = val;
    step();
  endtask

  initial begin
    #1_000_000;
    fail_now("global_watchdog");
    finish_test();
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; completions = 0;
    ap_valid = 1'b0; dp_valid = 1'b0; busy_noise = 1'b0;
    mdp_valid = 1'b0; mdp_wr = 1'b0; merr = 1'b0; merr_first = 1'b0;
    mdp_addr = 32'h0; mwait_left = 0;
    wait_min = 0; wait_max = 0; err_pct = 0; force_err = 0;
    n_hready = 1'b1; n_hresp = 1'b0; n_hrdata = 32'h0;
    load_word = 32'h0; caps_since_load = 0; cfg_req = 1'b0; cfg_val = 32'h0;
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_hready", {31'd0, s_hready}, 32'd1);
    check_eq("rst_s_hresp", {31'd0, s_hresp}, 32'd0);
    check_eq("rst_s_hrdata", s_hrdata, 32'h0);
    check_eq("rst_m_htrans", {30'd0, m_htrans}, 32'd0);
    check_eq("rst_m_haddr", m_haddr, 32'h0);
    check_eq("rst_m_hwdata", m_hwdata, 32'h0);
    check_eq("rst_m_ctrl", {21'd0, m_hwrite, m_hsize, m_hburst, m_hprot}, 32'd0);
    check_eq("rst_xfer_cnt", xfer_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unstalled single read, zero-wait memory.
    mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    txq.push_back(mk_tx(32'h100, 1'b0, 32'h0, 0));
    run_until_idle(50);
    check_eq("single_read_cnt", xfer_cnt, 32'd1);

    // MSB-only pattern: first of two back-to-back reads stalled, second not.
    load_cfg(32'h8000_0000);
    txq.push_back(mk_tx(32'h104, 1'b0, 32'h0, 0));
    txq.push_back(mk_tx(32'h108, 1'b0, 32'h0, 0));
    run_until_idle(60);

    // Write under a two-wait memory, then read it back.
    wait_min = 2; wait_max = 2;
    txq.push_back(mk_tx(32'h200, 1'b1, 32'h1234_5678, 0));
    txq.push_back(mk_tx(32'h200, 1'b0, 32'h0, 1));
    run_until_idle(60);

    // ERROR response with the next NONSEQ waiting on the bus.
    wait_min = 0; wait_max = 0; force_err = 1;
    txq.push_back(mk_tx(32'h240, 1'b1, 32'hCAFE_F00D, 0));
    txq.push_back(mk_tx(32'h240, 1'b0, 32'h0, 0));
    run_until_idle(60);

    // Asynchronous reset while the injector sits in its memory address phase.
    txq.push_back(mk_tx(32'h300, 1'b0, 32'h0, 0));
    for (int i = 0; i < 20 && m_htrans != 2'b10; i++) step();
    if (m_htrans != 2'b10) fail_now("reach_addr_phase");
    rst_n = 1'b0;
    #1;
    check_eq("midrst_m_htrans", {30'd0, m_htrans}, 32'd0);
    check_eq("midrst_s_hready", {31'd0, s_hready}, 32'd1);
    check_eq("midrst_xfer_cnt", xfer_cnt, 32'h0);
    txq.delete(); accq.delete(); mlog.delete();
    ap_valid = 1'b0; dp_valid = 1'b0; mdp_valid = 1'b0; completions = 0;
    load_word = 32'h0; caps_since_load = 0;
    n_hready = 1'b1; n_hresp = 1'b0; n_hrdata = 32'h0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txq.push_back(mk_tx(32'h100, 1'b0, 32'h0, 0));
    run_until_idle(50);

    // All-ones pattern over 32 fetches, switched to zero mid-stream.
    load_cfg(32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) txq.push_back(mk_tx(32'h400 + 32'(i) * 32'd4, 1'b0, 32'h0, 0));
    base = completions;
    for (int i = 0; i < 400 && completions < base + 16; i++) step();
    load_cfg(32'h0000_0000);
    run_until_idle(600);

    // Randomized traffic, waits, errors, BUSY noise and pattern reloads.
    wait_min = 0; wait_max = 2; err_pct = 10; busy_noise = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (txq.size() < 2 && $urandom_range(3, 0) != 0) txq.push_back(rand_tx());
      if ($urandom_range(49, 0) == 0) begin
        cfg_req = 1'b1;
        case ($urandom_range(3, 0))
          0:       cfg_val = 32'h0000_0000;
          1:       cfg_val = 32'hFFFF_FFFF;
          2:       cfg_val = 32'h8000_0001;
          default: cfg_val = $urandom;
        endcase
      end
      step();
    end
    run_until_idle(500);

    finish_test();
  end

endmodule
